// File: rtl/idli_pkg.sv
// Shared types for the idli trace buffer: FSM state encoding and common helpers.
package idli_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } trc_state_t;

   function automatic logic trc_capturing(input trc_state_t s);
      return (s == RUN) || (s == POST);
   endfunction

endpackage

// File: rtl/idli_trace_ram_m.sv
// DEPTH x WIDTH trace storage: one synchronous write port, one registered read port.
// A same-cycle read of the entry being written returns the previous contents.
module idli_trace_ram_m #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= mem_q[i_raddr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/idli_trace_m.sv
// Instruction trace buffer: reassembles the nibble-serial PC, stores offset-corrected
// PCs of retired instructions in a circular buffer. Optional trigger: IDLI_TRACE_TRIGGER_EN.
import idli_pkg::*;

module idli_trace_m #(
   parameter int WIDTH      = 16,
   parameter int SLICE      = 4,
   parameter int DEPTH      = 16,
   parameter int POST_DEPTH = 4,
   parameter int PC_OFS     = 1
) (
   input  logic                     i_trc_gck,
   input  logic                     i_trc_rst_n,
   input  logic                     i_trc_gate,
   input  logic [SLICE-1:0]         i_trc_pc_slice,
   input  logic                     i_trc_instr_done,
   input  logic                     i_trc_start,
   input  logic                     i_trc_stop,
   input  logic                     i_trc_arm,
   input  logic [WIDTH-1:0]         i_trc_trig_pc,
   input  logic                     i_trc_rd_req,
   input  logic [$clog2(DEPTH)-1:0] i_trc_rd_idx,
   output logic [WIDTH-1:0]         o_trc_rd_data,
   output logic                     o_trc_rd_vld,
   output logic [$clog2(DEPTH):0]   o_trc_count,
   output logic [1:0]               o_trc_state,
   output logic                     o_trc_triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] pc_q, pc_d, pc_corr;
   trc_state_t       state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rd_vld_q, rd_hit_q;
   logic [AW-1:0]    rd_addr;
   logic             rd_in_range;
   logic [WIDTH-1:0] ram_rdata;
   logic             cap_state;
   logic             capture;
   logic             trig_hit;

   // Slices arrive LSB first, so each gated cycle shifts the new slice in at the top.
   assign pc_d    = {i_trc_pc_slice, pc_q[WIDTH-1:SLICE]};
   assign pc_corr = pc_d - WIDTH'(PC_OFS);

`ifdef IDLI_TRACE_TRIGGER_EN
   logic [AW-1:0] post_cnt_q, post_cnt_d;
   logic          trig_q, trig_d;

   assign trig_hit        = i_trc_arm && (pc_corr == i_trc_trig_pc);
   assign cap_state       = (state_q == RUN) || ((state_q == POST) && (post_cnt_q != '0));
   assign o_trc_triggered = trig_q;
`else
   logic trig_unused;

   assign trig_unused     = ^{i_trc_arm, i_trc_trig_pc};
   assign trig_hit        = 1'b0;
   assign cap_state       = trc_capturing(state_q);
   assign o_trc_triggered = 1'b0;
`endif

   // Start and stop both suppress the write on their own cycle.
   assign capture = i_trc_gate && i_trc_instr_done && cap_state && !i_trc_start && !i_trc_stop;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
`ifdef IDLI_TRACE_TRIGGER_EN
      post_cnt_d = post_cnt_q;
      trig_d     = trig_q;
`endif
      if (capture) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (count_q != CW'(DEPTH)) begin
            count_d = count_q + CW'(1);
         end
      end
      if (i_trc_stop) begin
         state_d = FROZEN;
      end else if (i_trc_start) begin
         state_d  = RUN;
         wr_ptr_d = '0;
         count_d  = '0;
`ifdef IDLI_TRACE_TRIGGER_EN
         post_cnt_d = '0;
         trig_d     = 1'b0;
`endif
      end else begin
`ifdef IDLI_TRACE_TRIGGER_EN
         case (state_q)
            RUN: begin
               if (capture && trig_hit) begin
                  state_d    = POST;
                  post_cnt_d = AW'(POST_DEPTH);
                  trig_d     = 1'b1;
               end
            end
            POST: begin
               if (post_cnt_q == '0) begin
                  state_d = FROZEN;
               end else if (capture) begin
                  post_cnt_d = post_cnt_q - AW'(1);
               end
            end
            default: ;
         endcase
`endif
      end
   end

   always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
      if (!i_trc_rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
`ifdef IDLI_TRACE_TRIGGER_EN
         post_cnt_q <= '0;
         trig_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
`ifdef IDLI_TRACE_TRIGGER_EN
         post_cnt_q <= post_cnt_d;
         trig_q     <= trig_d;
`endif
      end
   end

   always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
      if (!i_trc_rst_n) begin
         pc_q <= '0;
      end else if (i_trc_gate) begin
         pc_q <= pc_d;
      end
   end

   // Index 0 is the oldest entry; when full, the oldest sits at the write pointer.
   assign rd_addr     = wr_ptr_q - count_q[AW-1:0] + i_trc_rd_idx;
   assign rd_in_range = {1'b0, i_trc_rd_idx} < count_q;

   always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
      if (!i_trc_rst_n) begin
         rd_vld_q <= 1'b0;
         rd_hit_q <= 1'b0;
      end else begin
         rd_vld_q <= i_trc_rd_req;
         rd_hit_q <= i_trc_rd_req && rd_in_range;
      end
   end

   idli_trace_ram_m #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (i_trc_gck),
      .i_rst_n (i_trc_rst_n),
      .i_we    (capture),
      .i_waddr (wr_ptr_q),
      .i_wdata (pc_corr),
      .i_re    (i_trc_rd_req),
      .i_raddr (rd_addr),
      .o_rdata (ram_rdata)
   );

   assign o_trc_rd_data = rd_hit_q ? ram_rdata : '0;
   assign o_trc_rd_vld  = rd_vld_q;
   assign o_trc_count   = count_q;
   assign o_trc_state   = state_q;

endmodule

// File: tb/tb_idli_trace_m.sv
// Self-checking bench for idli_trace_m: vector table, directed corner cases and a
// randomized run against a queue-based reference model.
import idli_pkg::*;

module tb_idli_trace_m;

`ifdef IDLI_TRACE_TRIGGER_EN
   localparam bit TRIG_EN = 1'b1;
`else
   localparam bit TRIG_EN = 1'b0;
`endif
   localparam int DEPTH      = 16;
   localparam int POST_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gate = 1'b0;
   logic [3:0]  slice = '0;
   logic        done = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        arm = 1'b0;
   logic [15:0] trigPc = '0;
   logic        rdReq = 1'b0;
   logic [3:0]  rdIdx = '0;
   logic [15:0] rdData;
   logic        rdVld;
   logic [4:0]  count;
   logic [1:0]  state;
   logic        triggered;

   int checks = 0;
   int errors = 0;

   logic [15:0] mq[$];
   trc_state_t  mState = IDLE;
   int          mPost = 0;
   bit          mTrig = 1'b0;

   typedef struct {
      logic [15:0] raw;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   idli_trace_m #(
      .WIDTH      (16),
      .SLICE      (4),
      .DEPTH      (DEPTH),
      .POST_DEPTH (POST_DEPTH),
      .PC_OFS     (1)
   ) dut (
      .i_trc_gck        (clk),
      .i_trc_rst_n      (rst_n),
      .i_trc_gate       (gate),
      .i_trc_pc_slice   (slice),
      .i_trc_instr_done (done),
      .i_trc_start      (start),
      .i_trc_stop       (stop),
      .i_trc_arm        (arm),
      .i_trc_trig_pc    (trigPc),
      .i_trc_rd_req     (rdReq),
      .i_trc_rd_idx     (rdIdx),
      .o_trc_rd_data    (rdData),
      .o_trc_rd_vld     (rdVld),
      .o_trc_count      (count),
      .o_trc_state      (state),
      .o_trc_triggered  (triggered)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] modelRead(input int idx);
      return (idx < mq.size()) ? mq[idx] : 16'h0;
   endfunction

   // Reference behaviour for one retired instruction with raw PC 'raw'.
   function automatic void modelRetire(input logic [15:0] raw);
      logic [15:0] corr;
      corr = raw - 16'd1;
      if (mState == RUN || (mState == POST && mPost > 0)) begin
         mq.push_back(corr);
         if (mq.size() > DEPTH) void'(mq.pop_front());
         if (mState == POST) begin
            mPost--;
         end else if (TRIG_EN && arm && corr == trigPc) begin
            mState = POST;
            mPost  = POST_DEPTH;
            mTrig  = 1'b1;
         end
      end
      if (mState == POST && mPost == 0) mState = FROZEN;
   endfunction

   task automatic applyStimulus(input logic [15:0] raw, input bit gaps);
      for (int s = 0; s < 4; s++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
               gate  = 1'b0;
               slice = 4'($urandom);
               done  = 1'($urandom);
               tick();
            end
         end
         gate  = 1'b1;
         slice = raw[4*s +: 4];
         done  = (s == 3);
         tick();
      end
      gate = 1'b0;
      done = 1'b0;
      tick();
      modelRetire(raw);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start  = 1'b0;
      mq.delete();
      mState = RUN;
      mPost  = 0;
      mTrig  = 1'b0;
   endtask

   task automatic pulseStop();
      stop = 1'b1;
      tick();
      stop   = 1'b0;
      mState = FROZEN;
   endtask

   task automatic readCheck(input string name, input int idx, input logic [15:0] exp);
      rdReq = 1'b1;
      rdIdx = 4'(idx);
      tick();
      rdReq = 1'b0;
      checkOutput({name, "_vld"}, 32'(rdVld), 32'd1);
      checkOutput(name, 32'(rdData), 32'(exp));
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
      tick();
      mq.delete();
      mState = IDLE;
      mPost  = 0;
      mTrig  = 1'b0;
   endtask

   initial begin
      logic [15:0] expOld;
      logic [15:0] raw;

      vecs[0] = '{raw: 16'h1234, exp: 16'h1233};
      vecs[1] = '{raw: 16'h0000, exp: 16'hFFFF};
      vecs[2] = '{raw: 16'h0001, exp: 16'h0000};
      vecs[3] = '{raw: 16'hFFFF, exp: 16'hFFFE};
      vecs[4] = '{raw: 16'h8000, exp: 16'h7FFF};
      vecs[5] = '{raw: 16'hA5C3, exp: 16'hA5C2};

      // Reset values
      tick();
      checkOutput("rst_state", 32'(state), 32'(IDLE));
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_vld", 32'(rdVld), 32'd0);
      checkOutput("rst_data", 32'(rdData), 32'd0);
      checkOutput("rst_trig", 32'(triggered), 32'd0);
      rst_n = 1'b1;
      tick();

      // Assembly and offset
      pulseStart();
      checkOutput("start_state", 32'(state), 32'(RUN));
      applyStimulus(16'h1234, 1'b0);
      checkOutput("asm_count", 32'(count), 32'd1);
      readCheck("asm_data", 0, 16'h1233);
      tick();
      checkOutput("vld_pulse", 32'(rdVld), 32'd0);

      // Vector table
      pulseStart();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].raw, 1'b0);
         checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(i + 1));
         readCheck($sformatf("vec%0d_data", i), i, vecs[i].exp);
      end
      readCheck("vec_oob", 7, 16'h0000);

      // Gating
      pulseStart();
      applyStimulus(16'h00A1, 1'b1);
      readCheck("gate_data", 0, 16'h00A0);
      gate = 1'b0;
      done = 1'b1;
      tick();
      tick();
      done = 1'b0;
      checkOutput("gate_nocap", 32'(count), 32'd1);

      // Wrap-around, plus same-cycle read/write of the oldest entry
      pulseStart();
      for (int p = 2; p <= 21; p++) applyStimulus(16'(p), 1'b0);
      checkOutput("wrap_count", 32'(count), 32'd16);
      readCheck("wrap_idx0", 0, 16'd5);
      readCheck("wrap_idx15", 15, 16'd20);
      expOld = mq[0];
      raw = 16'd22;
      for (int s = 0; s < 4; s++) begin
         gate  = 1'b1;
         slice = raw[4*s +: 4];
         done  = (s == 3);
         rdReq = (s == 3);
         rdIdx = 4'd0;
         tick();
      end
      gate  = 1'b0;
      done  = 1'b0;
      rdReq = 1'b0;
      checkOutput("rw_old", 32'(rdData), 32'(expOld));
      modelRetire(raw);
      readCheck("rw_new_idx15", 15, 16'd21);
      pulseStart();
      readCheck("restart_idx3", 3, 16'h0000);

      // Priority
      doReset();
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("prio_state", 32'(state), 32'(FROZEN));
      checkOutput("prio_count", 32'(count), 32'd0);
      pulseStart();
      raw = 16'h0042;
      for (int s = 0; s < 4; s++) begin
         gate  = 1'b1;
         slice = raw[4*s +: 4];
         done  = (s == 3);
         start = (s == 3);
         tick();
      end
      gate  = 1'b0;
      done  = 1'b0;
      start = 1'b0;
      checkOutput("start_nocap", 32'(count), 32'd0);
      applyStimulus(16'h0050, 1'b0);
      raw = 16'h0060;
      for (int s = 0; s < 4; s++) begin
         gate  = 1'b1;
         slice = raw[4*s +: 4];
         done  = (s == 3);
         stop  = (s == 3);
         tick();
      end
      gate = 1'b0;
      done = 1'b0;
      stop = 1'b0;
      mState = FROZEN;
      checkOutput("stop_nocap", 32'(count), 32'd1);
      checkOutput("stop_state", 32'(state), 32'(FROZEN));
      applyStimulus(16'h0070, 1'b0);
      checkOutput("frozen_nocap", 32'(count), 32'd1);

      // Randomized run against the queue model
      pulseStart();
      for (int n = 0; n < 40; n++) applyStimulus(16'($urandom), 1'b1);
      checkOutput("rand_count", 32'(count), 32'(mq.size()));
      for (int i = 0; i < DEPTH; i++) begin
         rdReq = 1'b1;
         rdIdx = 4'(i);
         tick();
         checkOutput($sformatf("rand_vld%0d", i), 32'(rdVld), 32'd1);
         checkOutput($sformatf("rand_data%0d", i), 32'(rdData), 32'(modelRead(i)));
      end
      rdReq = 1'b0;
      tick();
      checkOutput("rand_vld_end", 32'(rdVld), 32'd0);

`ifdef IDLI_TRACE_TRIGGER_EN
      // Trigger with post-capture window
      arm    = 1'b1;
      trigPc = 16'h0100;
      pulseStart();
      for (int p = 16'h00FD; p <= 16'h0110; p++) begin
         applyStimulus(16'(p), 1'b0);
         if (p == 16'h0105) checkOutput("trig_frozen_at", 32'(state), 32'(FROZEN));
      end
      checkOutput("trig_flag", 32'(triggered), 32'd1);
      checkOutput("trig_state", 32'(state), 32'(FROZEN));
      checkOutput("trig_count", 32'(count), 32'd9);
      checkOutput("trig_model_count", 32'(count), 32'(mq.size()));
      readCheck("trig_last", 8, 16'h0104);

      // Stop in POST
      pulseStart();
      applyStimulus(16'h0101, 1'b0);
      checkOutput("post_state", 32'(state), 32'(POST));
      pulseStop();
      checkOutput("post_stop", 32'(state), 32'(FROZEN));

      // Back into POST before the asynchronous reset below
      pulseStart();
      applyStimulus(16'h0101, 1'b0);
      checkOutput("post_again", 32'(state), 32'(POST));
      arm = 1'b0;
`endif

      // Asynchronous reset while read data is being presented
      rdReq = 1'b1;
      rdIdx = 4'd0;
      tick();
      rdReq = 1'b0;
      checkOutput("pre_rst_vld", 32'(rdVld), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_state", 32'(state), 32'(IDLE));
      checkOutput("arst_count", 32'(count), 32'd0);
      checkOutput("arst_vld", 32'(rdVld), 32'd0);
      checkOutput("arst_data", 32'(rdData), 32'd0);
      checkOutput("arst_trig", 32'(triggered), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_state", 32'(state), 32'(IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
